alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter W, default 32, meaning datapath width (≥8, power of 2).
REQ-002 SHALL have parameter SHW, default $clog2(W), meaning the number of shift-amount bits taken from B.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port clr_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  operation request; sampled only when busy=0.
REQ-006 SHALL have port opcode  in  5  operation select; sampled with start.
REQ-007 SHALL have ports A, B  in  W  operands; sampled with start.
REQ-008 SHALL have port busy  out  1  multi-cycle operation in progress.
REQ-009 SHALL have port done  out  1  one-cycle pulse; results valid.
REQ-010 SHALL have port result  out  W  primary result (LO for mul/div).
REQ-011 SHALL have ports HI, LO  out  W  mul: {HI,LO} product; div: HI remainder, LO quotient.
REQ-012 SHALL have ports div_zero, illegal  out  1  status flags; valid with done, held until the next accept.

Function
REQ-013 SHALL decode opcodes: Add 00011, Sub 00100, Shr 00101, Shra 00110, Shl 00111, Ror 01000, Rol 01001, And 01010, Or 01011, Mul 01111, Div 10000, Neg 10001, Not 10010.
REQ-014 SHALL accept a request on any rising edge with start=1 and busy=0; start while busy=1 is ignored.
REQ-015 SHALL complete single-cycle ops (all except Mul/Div) with done=1 and result updated one edge after accept; busy stays 0.
REQ-016 SHALL compute Add/Sub mod 2^W (no carry out); shifts/rotates by B[SHW-1:0]; Shra sign-fills; Neg = 0-A; Not = ~A.
REQ-017 SHALL for single-cycle ops leave HI unchanged and set LO=result.
REQ-018 SHALL use FSM states IDLE, CALC, FIX, DONE: IDLE→CALC on Mul/Div accept; CALC for exactly W cycles (one bit per cycle: shift-add multiply, restoring divide on magnitudes); FIX applies signs (one cycle); DONE pulses done and returns to IDLE.
REQ-019 SHALL assert busy from the accept edge through FIX; done rises on edge accept+W+2, busy falls on the same edge.
REQ-020 SHALL treat Mul/Div operands as two's-complement signed; product sign = sign(A)^sign(B); quotient truncates toward zero; remainder takes the dividend's sign.
REQ-021 SHALL, for Div with B=0, skip CALC, produce done on edge accept+1, LO=all ones, HI=A, result=all ones, div_zero=1.
REQ-022 SHALL, for Div of most-negative by -1, return LO=most-negative (wrap), HI=0, div_zero=0.
REQ-023 SHALL, for an undefined opcode, complete in one cycle with result=0, HI/LO unchanged, illegal=1.
REQ-024 SHALL hold result, HI, LO, and flags stable after done until the next accepted request completes.
REQ-025 SHALL accept a new start in the same cycle done is high (back-to-back, zero bubble).

Reset
REQ-026 SHALL, on clr_n=0 (asynchronous, any state including mid-CALC), force state IDLE, busy=0, done=0, result=0, HI=0, LO=0, div_zero=0, illegal=0, and discard the in-flight operation.
REQ-027 SHALL leave reset release synchronous in effect: no accept on the edge where clr_n rises.

Structure
REQ-028 SHALL place opcode localparams and the FSM state enum in shared package alu_pkg, reused by the control unit.
REQ-029 SHALL implement the iterative mul/div datapath (magnitude convert, W-step shift register, sign fix) as sub-module muldiv_seq; alu_multicycle holds the single-cycle ops, FSM, and output registers.

Verification (W=32)
REQ-030 SHALL cover: Add A=0x7FFFFFFF, B=1 -> result 0x80000000 one edge after accept, busy never 1.
REQ-031 SHALL cover: Mul A=-3 (0xFFFFFFFD), B=7 -> done at accept+34, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-032 SHALL cover: Div A=-17, B=5 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFE (-2); and A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
REQ-033 SHALL cover: Div B=0, A=0x1234 -> done at accept+1, div_zero=1, LO=0xFFFFFFFF, HI=0x1234.
REQ-034 SHALL cover: start pulsed during Mul busy -> ignored; start with Ror A=0x00000001, B=1 on the done cycle -> accepted, result 0x80000000.
REQ-035 SHALL cover: clr_n low at CALC cycle 10 -> all outputs 0 immediately; the next Mul after release gives the correct full result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and control FSM states for the multi-cycle ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    function automatic logic is_iterative(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide: magnitudes on load, one bit per step,
// signs restored in a single fix cycle.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [4:0]   op,
    input  logic         step,
    input  logic         fix,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    logic [W-1:0]   hi_reg, lo_reg, mb_reg;
    logic           div_reg, neg_q_reg, neg_r_reg;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [2*W-1:0] prod_neg;

    // Magnitude of the most-negative value still fits as an unsigned W-bit number.
    assign a_mag     = a[W-1] ? (W'(0) - a) : a;
    assign b_mag     = b[W-1] ? (W'(0) - b) : b;
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mb_reg} : {(W+1){1'b0}});
    assign div_shift = {hi_reg, lo_reg[W-1]};
    assign div_diff  = div_shift - {1'b0, mb_reg};
    assign prod_neg  = (2*W)'(0) - {hi_reg, lo_reg};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hi_reg    <= '0;
            lo_reg    <= '0;
            mb_reg    <= '0;
            div_reg   <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (load) begin
            hi_reg    <= '0;
            lo_reg    <= a_mag;
            mb_reg    <= b_mag;
            div_reg   <= (op == OP_DIV);
            neg_q_reg <= a[W-1] ^ b[W-1];
            neg_r_reg <= a[W-1];
        end else if (step) begin
            if (div_reg) begin
                // Restoring step: a clear top bit of the difference means no borrow.
                if (!div_diff[W]) begin
                    hi_reg <= div_diff[W-1:0];
                    lo_reg <= {lo_reg[W-2:0], 1'b1};
                end else begin
                    hi_reg <= div_shift[W-1:0];
                    lo_reg <= {lo_reg[W-2:0], 1'b0};
                end
            end else begin
                {hi_reg, lo_reg} <= {mul_sum, lo_reg[W-1:1]};
            end
        end else if (fix) begin
            if (div_reg) begin
                if (neg_q_reg) lo_reg <= W'(0) - lo_reg;
                if (neg_r_reg) hi_reg <= W'(0) - hi_reg;
            end else if (neg_q_reg) begin
                {hi_reg, lo_reg} <= prod_neg;
            end
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: rtl/alu_multicycle.sv
// ALU with single-cycle logic/arith/shift ops and an iterative signed mul/div,
// sequenced by a small control FSM with registered outputs.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic [4:0]   opcode,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [W-1:0] HI,
    output logic [W-1:0] LO,
    output logic         div_zero,
    output logic         illegal
);

    localparam int CW = $clog2(W);

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg;
    logic           run_reg, busy_reg, done_reg;
    logic [4:0]     op_reg;
    logic [W-1:0]   a_reg, b_reg;
    logic [W-1:0]   result_reg, hi_reg, lo_reg;
    logic           div_zero_reg, illegal_reg;
    logic           accept, long_op, md_load, step_en, fix_en, div0_op;
    logic [W-1:0]   md_hi, md_lo, alu_res;
    logic           alu_legal;
    logic [SHW-1:0] sh;
    logic [2*W-1:0] ror_dbl, rol_dbl;

    // run_reg keeps the edge on which clr_n is released from accepting a request.
    assign accept  = start && !busy_reg && run_reg;
    assign long_op = is_iterative(opcode) && !((opcode == OP_DIV) && (B == '0));
    assign md_load = accept && long_op;
    assign step_en = (state_reg == CALC);
    assign fix_en  = (state_reg == FIX);
    assign div0_op = (op_reg == OP_DIV) && (b_reg == '0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: state_next = accept ? (long_op ? CALC : DONE) : IDLE;
            CALC:       if (cnt_reg == CW'(W - 1)) state_next = FIX;
            FIX:        state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            run_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
            cnt_reg   <= (state_reg == CALC) ? cnt_reg + 1'b1 : '0;
            // Only iterative ops show busy; single-cycle ops pass through DONE unflagged.
            busy_reg  <= (state_next == CALC) || (state_next == FIX) ||
                         ((state_next == DONE) && (state_reg == FIX));
            done_reg  <= (state_reg == DONE);
            if (accept) begin
                op_reg <= opcode;
                a_reg  <= A;
                b_reg  <= B;
            end
        end
    end

    assign sh = b_reg[SHW-1:0];

    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        ror_dbl   = {a_reg, a_reg} >> sh;
        rol_dbl   = {a_reg, a_reg} << sh;
        case (op_reg)
            OP_ADD:  alu_res = a_reg + b_reg;
            OP_SUB:  alu_res = a_reg - b_reg;
            OP_SHR:  alu_res = a_reg >> sh;
            OP_SHRA: alu_res = $signed(a_reg) >>> sh;
            OP_SHL:  alu_res = a_reg << sh;
            OP_ROR:  alu_res = ror_dbl[W-1:0];
            OP_ROL:  alu_res = rol_dbl[2*W-1:W];
            OP_AND:  alu_res = a_reg & b_reg;
            OP_OR:   alu_res = a_reg | b_reg;
            OP_NEG:  alu_res = W'(0) - a_reg;
            OP_NOT:  alu_res = ~a_reg;
            OP_MUL, OP_DIV: alu_res = '0;
            default: alu_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            result_reg   <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            div_zero_reg <= 1'b0;
            illegal_reg  <= 1'b0;
        end else if (state_reg == DONE) begin
            div_zero_reg <= 1'b0;
            illegal_reg  <= 1'b0;
            if (div0_op) begin
                result_reg   <= '1;
                lo_reg       <= '1;
                hi_reg       <= a_reg;
                div_zero_reg <= 1'b1;
            end else if (is_iterative(op_reg)) begin
                result_reg <= md_lo;
                lo_reg     <= md_lo;
                hi_reg     <= md_hi;
            end else if (alu_legal) begin
                result_reg <= alu_res;
                lo_reg     <= alu_res;
            end else begin
                result_reg  <= '0;
                illegal_reg <= 1'b1;
            end
        end
    end

    muldiv_seq #(.W(W)) u_muldiv (
        .clk   (clk),
        .clr_n (clr_n),
        .load  (md_load),
        .op    (opcode),
        .step  (step_en),
        .fix   (fix_en),
        .a     (A),
        .b     (B),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign result   = result_reg;
    assign HI       = hi_reg;
    assign LO       = lo_reg;
    assign div_zero = div_zero_reg;
    assign illegal  = illegal_reg;

endmodule
